// File: rtl/reg_array_fill.sv
// DEPTH x WIDTH register array with a bit-masked write port, a registered read port
// and a sequencer that bulk-fills every entry with a latched pattern, one per cycle.
module reg_array_fill #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic             wr_err,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             fill_start,
    input  logic [WIDTH-1:0] fill_data,
    output logic             fill_busy,
    output logic             fill_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] mem [DEPTH];

    logic wr_in_range;
    logic rd_in_range;
    logic wr_ok;

    // Addresses beyond DEPTH are representable when DEPTH is not a power of two.
    assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
    assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));
    assign wr_ok       = wr_en && (state != FILL) && wr_in_range;

    assign fill_busy = (state == FILL);
    assign fill_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = FILL;
            FILL:    if (ptr == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            pattern <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && fill_start) begin
                pattern <= fill_data;
                ptr     <= '0;
            end else if (state == FILL) begin
                ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

    // Sole writer of the array: the fill sequencer has priority over user writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == FILL) begin
            mem[ptr] <= pattern;
        end else if (wr_ok) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            wr_err   <= wr_en && ((state == FILL) || !wr_in_range);
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_array_fill.sv
// Directed bench for reg_array_fill: vector table for masked writes and reads, plus
// hand-written sequences for fill timing, fill collisions, out-of-range and reset mid-fill.
module tb_reg_array_fill;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] wr_mask;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       fill_start;
    logic [7:0] fill_data;

    logic       wr_err,    rd_valid,    fill_busy,    fill_done;
    logic [7:0] rd_data;
    logic       wr_err_12, rd_valid_12, fill_busy_12, fill_done_12;
    logic [7:0] rd_data_12;

    int total;
    int bad;

    typedef struct {
        logic       wr_en;
        logic [3:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] wr_mask;
        logic       rd_en;
        logic [3:0] rd_addr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [11];

    reg_array_fill #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_err(wr_err),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(fill_busy), .fill_done(fill_done)
    );

    reg_array_fill #(.WIDTH(8), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_err(wr_err_12),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_12), .rd_valid(rd_valid_12),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(fill_busy_12), .fill_done(fill_done_12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                input logic [7:0] wm, input logic re, input logic [3:0] ra,
                                input logic ev, input logic [7:0] ed, input logic ee);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_mask = wm;
        v.rd_en = re; v.rd_addr = ra;
        v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic read_all(input logic [7:0] exp, input string name);
        for (int i = 0; i < 16; i++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(i);
            step();
            check($sformatf("%s_valid[%0d]", name, i), rd_valid, 1'b1);
            check($sformatf("%s_data[%0d]", name, i), rd_data, exp);
        end
        rd_en = 1'b0;
        step();
        check($sformatf("%s_valid_drop", name), rd_valid, 1'b0);
    endtask

    // Fill started at edge T; cycle k samples the outputs just after edge T+k.
    task automatic do_fill(input logic [7:0] pat, input bit extras);
        fill_start = 1'b1;
        fill_data  = pat;
        step();
        fill_start = 1'b0;
        check("fill_busy_after_start", fill_busy, 1'b1);
        check("fill_done_after_start", fill_done, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            if (extras && k == 1) begin
                fill_start = 1'b1;
                fill_data  = ~pat;
            end
            if (extras && (k == 3 || k == 4)) begin
                rd_en   = 1'b1;
                rd_addr = 4'd2;
            end
            if (extras && k == 5) begin
                wr_en   = 1'b1;
                wr_addr = 4'd0;
                wr_data = 8'h00;
                wr_mask = 8'hFF;
            end
            step();
            fill_start = 1'b0;
            rd_en      = 1'b0;
            wr_en      = 1'b0;
            check($sformatf("fill_busy_k%0d", k), fill_busy, (k < 16) ? 1'b1 : 1'b0);
            check($sformatf("fill_done_k%0d", k), fill_done, (k == 16) ? 1'b1 : 1'b0);
            if (extras) begin
                check($sformatf("fill_wr_err_k%0d", k), wr_err, (k == 5) ? 1'b1 : 1'b0);
                if (k == 3) check("fill_read_unwritten", rd_data, 8'h00);
                if (k == 4) check("fill_read_written", rd_data, pat);
            end
        end
    endtask

    initial begin
        int done_seen;
        int busy_seen;

        total = 0;
        bad   = 0;
        vecs[0]  = mk(1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0, 4'd0, 1'b0, 8'h00, 1'b0);
        vecs[1]  = mk(1'b1, 4'd3, 8'h00, 8'h0F, 1'b1, 4'd3, 1'b1, 8'hFF, 1'b0);
        vecs[2]  = mk(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 1'b1, 8'hF0, 1'b0);
        vecs[3]  = mk(1'b1, 4'd5, 8'h11, 8'hFF, 1'b0, 4'd0, 1'b0, 8'hF0, 1'b0);
        vecs[4]  = mk(1'b1, 4'd5, 8'h22, 8'hFF, 1'b1, 4'd5, 1'b1, 8'h11, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5, 1'b1, 8'h22, 1'b0);
        vecs[6]  = mk(1'b1, 4'd7, 8'h5A, 8'h00, 1'b1, 4'd7, 1'b1, 8'h00, 1'b0);
        vecs[7]  = mk(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd7, 1'b1, 8'h00, 1'b0);
        vecs[8]  = mk(1'b1, 4'd6, 8'hC3, 8'hF0, 1'b1, 4'd6, 1'b1, 8'h00, 1'b0);
        vecs[9]  = mk(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd6, 1'b1, 8'hC0, 1'b0);
        vecs[10] = mk(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0, 8'hC0, 1'b0);

        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_en = 1'b0; rd_addr = '0;
        fill_start = 1'b0; fill_data = '0;
        step();
        step();
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_rd_valid", rd_valid, 1'b0);
        check("reset_wr_err", wr_err, 1'b0);
        check("reset_fill_busy", fill_busy, 1'b0);
        check("reset_fill_done", fill_done, 1'b0);
        rst_n = 1'b1;
        step();

        read_all(8'h00, "reset_read");

        for (int i = 0; i < 11; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            wr_mask = vecs[i].wr_mask;
            rd_en   = vecs[i].rd_en;
            rd_addr = vecs[i].rd_addr;
            step();
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d_wr_err", i), wr_err, vecs[i].exp_err);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        do_fill(8'hA5, 1'b1);
        read_all(8'hA5, "fill_a5");

        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'hFF; wr_mask = 8'hFF;
        step();
        wr_en = 1'b0;
        check("d12_oor_wr_err", wr_err_12, 1'b1);
        check("d16_addr13_wr_err", wr_err, 1'b0);
        rd_en = 1'b1; rd_addr = 4'd13;
        step();
        check("d12_wr_err_pulse_end", wr_err_12, 1'b0);
        check("d12_oor_rd_valid", rd_valid_12, 1'b1);
        check("d12_oor_rd_data", rd_data_12, 8'h00);
        check("d16_addr13_rd_data", rd_data, 8'hFF);
        rd_addr = 4'd11;
        step();
        rd_en = 1'b0;
        check("d12_last_entry", rd_data_12, 8'hA5);

        fill_start = 1'b1;
        fill_data  = 8'h96;
        step();
        fill_start = 1'b0;
        repeat (6) step();
        check("midfill_busy_before_reset", fill_busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midfill_reset_busy", fill_busy, 1'b0);
        check("midfill_reset_done", fill_done, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fill_done) done_seen++;
            if (fill_busy) busy_seen++;
        end
        check("midfill_no_done", 32'(done_seen), 32'd0);
        check("midfill_no_busy", 32'(busy_seen), 32'd0);
        read_all(8'h00, "after_abort");

        do_fill(8'h3C, 1'b0);
        read_all(8'h3C, "fill_3c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
